// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the coin tracker slice.
//   coin_state_t  - tracker FSM states (IDLE=0, PLAY=1, REVEAL=2, DONE=3)
//   NUM_COINS     - number of coins per level (fixed at 3)
//   count_zeros3  - number of cleared bits in a 3-bit coin mask
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    REVEAL = 2'd2,
    DONE   = 2'd3
  } coin_state_t;

  localparam int NUM_COINS = 3;

  // A cleared bit means the coin was collected, so zeros are what we count.
  function automatic logic [1:0] count_zeros3(input logic [2:0] coins);
    logic [1:0] total;
    total = {1'b0, ~coins[0]} + {1'b0, ~coins[1]} + {1'b0, ~coins[2]};
    return total;
  endfunction

endpackage

// File: rtl/vsync_edge.sv
// vsync_edge: brings the VGA vsync (frame_clk) into the Clk domain through a
// two-flop synchroniser and emits a one-Clk pulse on each synchronised rising
// edge.
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   async_in   - asynchronous level input (vsync)
//   rise_pulse - registered one-cycle pulse per rising edge of async_in
module vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic sync3_r;
  logic rise_r;

  // Synchroniser chain, a history flop for edge detection and the pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      rise_r  <= sync2_r & ~sync3_r;
    end
  end

  assign rise_pulse = rise_r;

endmodule

// File: rtl/coin_tracker.sv
// coin_tracker: tracks which of the level's three coins are still uncollected
// and, on a win, reveals one star per REVEAL_FRAMES video frames.
// Optional feature macro: STAR_REVEAL_ANIM_EN. When undefined, a win jumps
// straight to DONE and the final coin mask is shown without animation.
// Ports:
//   Clk             - 50 MHz system clock
//   Reset           - asynchronous active-low reset
//   frame_clk       - VGA vsync, asynchronous
//   level_start     - pulse, (re)starts a level with all coins present
//   coin_hit[2:0]   - per-coin collision pulses
//   game_win        - pulse, player reached the goal
//   game_lose       - pulse, player died
//   CoinStatus[2:0] - 1 = coin/star still drawn as uncollected
//   collected_count - number of collected coins (one cycle behind the mask)
//   reveal_done     - high while in DONE
//   state_out       - FSM state encoding for debug
module coin_tracker
  import game_pkg::*;
#(
  parameter int REVEAL_FRAMES = 30,
  parameter int NUM_COINS     = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       level_start,
  input  logic [2:0] coin_hit,
  input  logic       game_win,
  input  logic       game_lose,
  output logic [2:0] CoinStatus,
  output logic [1:0] collected_count,
  output logic       reveal_done,
  output logic [1:0] state_out
);

  if (NUM_COINS != game_pkg::NUM_COINS) begin : g_bad_num_coins
    $error("coin_tracker: NUM_COINS must be 3");
  end

  if ((REVEAL_FRAMES < 1) || (REVEAL_FRAMES > 255)) begin : g_bad_reveal_frames
    $error("coin_tracker: REVEAL_FRAMES must be in 1..255");
  end

  coin_state_t state_r;
  coin_state_t state_next_s;
  logic [2:0]  coin_r;
  logic [2:0]  coin_next_s;
  logic [2:0]  status_r;
  logic [2:0]  status_next_s;
  logic [1:0]  count_r;
  logic        done_r;
  logic        frame_tick_s;

  vsync_edge u_vsync_edge (
    .clk        (Clk),
    .rst_n      (Reset),
    .async_in   (frame_clk),
    .rise_pulse (frame_tick_s)
  );

`ifdef STAR_REVEAL_ANIM_EN
  localparam logic [7:0] FRAME_LAST = 8'(REVEAL_FRAMES - 1);

  logic [7:0] frame_cnt_r;
  logic [7:0] frame_next_s;
  logic [1:0] shown_r;
  logic [1:0] shown_next_s;
  logic [1:0] coins_won_s;

  // The coin mask is frozen during the reveal, so its zero count is the target.
  assign coins_won_s = count_zeros3(coin_r);

  // Reveal frame counter and number of stars already shown.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_cnt_r <= 8'd0;
      shown_r     <= 2'd0;
    end else begin
      frame_cnt_r <= frame_next_s;
      shown_r     <= shown_next_s;
    end
  end
`else
  logic frame_tick_unused_s;
  localparam int REVEAL_FRAMES_UNUSED = REVEAL_FRAMES;
  assign frame_tick_unused_s = frame_tick_s;
`endif

  // Next-state, next coin mask and next displayed status.
  always_comb begin
    state_next_s  = state_r;
    coin_next_s   = coin_r;
    status_next_s = status_r;
`ifdef STAR_REVEAL_ANIM_EN
    frame_next_s  = frame_cnt_r;
    shown_next_s  = shown_r;
`endif
    case (state_r)
      IDLE: begin
        if (level_start) begin
          state_next_s = PLAY;
          coin_next_s  = 3'b111;
        end else begin
          coin_next_s  = coin_r;
        end
        status_next_s = coin_next_s;
      end
      PLAY: begin
        // A restart takes precedence over any hit/win/lose in the same cycle.
        if (level_start) begin
          coin_next_s   = 3'b111;
          status_next_s = 3'b111;
        end else begin
          // Hits landing with game_win still count toward the result.
          coin_next_s   = coin_r & ~coin_hit;
          status_next_s = coin_next_s;
          if (game_win) begin
`ifdef STAR_REVEAL_ANIM_EN
            state_next_s  = REVEAL;
            status_next_s = 3'b111;
            frame_next_s  = 8'd0;
            shown_next_s  = 2'd0;
`else
            state_next_s  = DONE;
`endif
          end else if (game_lose) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = PLAY;
          end
        end
      end
`ifdef STAR_REVEAL_ANIM_EN
      REVEAL: begin
        if (level_start) begin
          state_next_s  = PLAY;
          coin_next_s   = 3'b111;
          status_next_s = 3'b111;
          frame_next_s  = 8'd0;
          shown_next_s  = 2'd0;
        end else if (frame_tick_s) begin
          if (frame_cnt_r == FRAME_LAST) begin
            frame_next_s = 8'd0;
            if (shown_r < coins_won_s) begin
              shown_next_s = shown_r + 2'd1;
            end else begin
              shown_next_s = shown_r;
            end
            // Finish on the period that shows the last star; with no coins
            // this is simply the first full period.
            if (shown_next_s == coins_won_s) begin
              state_next_s = DONE;
            end else begin
              state_next_s = REVEAL;
            end
          end else begin
            frame_next_s = frame_cnt_r + 8'd1;
          end
          status_next_s = 3'b111 << shown_next_s;
        end else begin
          state_next_s = REVEAL;
        end
      end
`endif
      DONE: begin
        if (level_start) begin
          state_next_s  = PLAY;
          coin_next_s   = 3'b111;
          status_next_s = 3'b111;
        end else begin
          state_next_s  = DONE;
        end
      end
      default: begin
        state_next_s  = IDLE;
        coin_next_s   = 3'b111;
        status_next_s = 3'b111;
      end
    endcase
  end

  // Main state, coin mask and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r  <= IDLE;
      coin_r   <= 3'b111;
      status_r <= 3'b111;
      count_r  <= 2'd0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      coin_r   <= coin_next_s;
      status_r <= status_next_s;
      count_r  <= count_zeros3(coin_r);
      done_r   <= (state_next_s == DONE);
    end
  end

  assign CoinStatus      = status_r;
  assign collected_count = count_r;
  assign reveal_done     = done_r;
  assign state_out       = state_r;

endmodule

// File: tb/tb_coin_tracker.sv
// tb_coin_tracker: randomized self-checking bench for coin_tracker. The
// reference model tracks the game at the level of "which coins are left",
// "how many frames since the win" and derives the displayed stars from them.
module tb_coin_tracker;

  localparam int RF = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       level_start;
  logic [2:0] coin_hit;
  logic       game_win;
  logic       game_lose;
  logic [2:0] CoinStatus;
  logic [1:0] collected_count;
  logic       reveal_done;
  logic [1:0] state_out;

  int tests_run    = 0;
  int tests_failed = 0;

  // model: 0 idle, 1 play, 2 reveal, 3 done
  int         m_state;
  logic [2:0] m_coins;
  int         m_k;
  int         m_t;

`ifdef STAR_REVEAL_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  coin_tracker #(.REVEAL_FRAMES(RF), .NUM_COINS(3)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_clk       (frame_clk),
    .level_start     (level_start),
    .coin_hit        (coin_hit),
    .game_win        (game_win),
    .game_lose       (game_lose),
    .CoinStatus      (CoinStatus),
    .collected_count (collected_count),
    .reveal_done     (reveal_done),
    .state_out       (state_out)
  );

  always #10 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int zeros(input logic [2:0] c);
    int n = 0;
    for (int i = 0; i < 3; i++) if (c[i] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [2:0] exp_status();
    logic [2:0] all_on = 3'b111;
    int shown;
    if (m_state == 2) begin
      shown = m_t / RF;
      if (shown > m_k) shown = m_k;
      return all_on << shown;
    end else if (m_state == 3 && ANIM) begin
      return all_on << m_k;
    end
    return m_coins;
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".state"}, 8'(state_out), 8'(m_state));
    check_val({tag, ".status"}, 8'(CoinStatus), 8'(exp_status()));
    check_val({tag, ".count"}, 8'(collected_count), 8'(zeros(m_coins)));
    check_val({tag, ".done"}, 8'(reveal_done), 8'(m_state == 3));
  endtask

  // One-cycle stimulus pulse, model update, then settle two cycles.
  task automatic drive(input logic ls, input logic [2:0] hit, input logic win, input logic lose);
    @(negedge Clk);
    level_start = ls; coin_hit = hit; game_win = win; game_lose = lose;
    if (ls) begin
      m_state = 1; m_coins = 3'b111;
    end else if (m_state == 1) begin
      m_coins = m_coins & ~hit;
      if (win) begin
        m_state = ANIM ? 2 : 3;
        m_k = zeros(m_coins);
        m_t = 0;
      end else if (lose) begin
        m_state = 0;
      end
    end
    @(negedge Clk);
    level_start = 1'b0; coin_hit = 3'b000; game_win = 1'b0; game_lose = 1'b0;
    @(negedge Clk);
  endtask

  task automatic frame_pulse();
    int need;
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    if (m_state == 2) begin
      m_t++;
      need = (m_k > 0 ? m_k : 1) * RF;
      if (m_t >= need) m_state = 3;
    end
  endtask

  task automatic mid_reset();
    @(negedge Clk);
    #3 Reset = 1'b0;
    #1;
    m_state = 0; m_coins = 3'b111;
    check_val("async_rst.state", 8'(state_out), 8'd0);
    check_val("async_rst.status", 8'(CoinStatus), 8'd7);
    check_val("async_rst.count", 8'(collected_count), 8'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    int r;
    Reset = 1'b0; frame_clk = 1'b0; level_start = 1'b0;
    coin_hit = 3'b000; game_win = 1'b0; game_lose = 1'b0;
    m_state = 0; m_coins = 3'b111; m_k = 0; m_t = 0;
    repeat (2) @(negedge Clk);
    check_all("reset");
    Reset = 1'b1;
    @(negedge Clk);
    check_all("post_reset");

    // level start and coin collection
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    check_val("start.status", 8'(CoinStatus), 8'd7);
    check_val("start.state", 8'(state_out), 8'd1);
    check_all("start");
    drive(1'b0, 3'b101, 1'b0, 1'b0);
    check_val("hit101.status", 8'(CoinStatus), 8'd2);
    check_val("hit101.count", 8'(collected_count), 8'd2);
    drive(1'b0, 3'b010, 1'b0, 1'b0);
    check_val("hit010.status", 8'(CoinStatus), 8'd0);
    check_val("hit010.count", 8'(collected_count), 8'd3);
    drive(1'b0, 3'b111, 1'b0, 1'b0);
    check_all("rehit");

    // win + lose + hit in the same cycle
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b001, 1'b1, 1'b1);
    check_val("winlose.state", 8'(state_out), ANIM ? 8'd2 : 8'd3);
    check_val("winlose.count", 8'(collected_count), 8'd1);
    check_all("winlose");
    repeat (2) begin
      frame_pulse();
      check_all("winlose_frame");
    end
    drive(1'b0, 3'b010, 1'b0, 1'b1);
    check_all("ignored_in_reveal");
    repeat (3) begin
      frame_pulse();
      check_all("winlose_frame2");
    end

    // two coins, then win and walk the reveal
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b011, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    check_all("win2");
    for (int f = 1; f <= 5; f++) begin
      frame_pulse();
      check_all($sformatf("win2_frame%0d", f));
    end
    check_val("win2.final_status", 8'(CoinStatus), ANIM ? 8'd4 : 8'd4);
    check_val("win2.final_done", 8'(reveal_done), 8'd1);

    // reset during a reveal, then frames do nothing
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b110, 1'b1, 1'b0);
    frame_pulse();
    check_all("pre_reset");
    mid_reset();
    check_all("after_reset");
    repeat (3) frame_pulse();
    check_all("frames_in_idle");

    // randomized operations
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0:       drive(1'b1, 3'b000, 1'b0, 1'b0);
        1, 2, 3: drive(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        4:       drive(1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
        5:       drive(1'b0, 3'b000, 1'b0, 1'b1);
        6:       drive(1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b1);
        7, 8, 9, 10: frame_pulse();
        default: begin
          if ($urandom_range(0, 3) == 0) mid_reset();
          else drive(1'b1, 3'b000, 1'b0, 1'b0);
        end
      endcase
      check_all($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/coin_tracker.md
COIN_TRACKER -- requirements
Module: coin_tracker

Interface
REQ-001 Parameter REVEAL_FRAMES, default 30: frames between successive star reveals on the win screen; legal range 1..255.
REQ-002 Parameter NUM_COINS, default 3: fixed at 3; any other value is a synthesis error.
REQ-003 Clk  input  1: 50 MHz system clock; all state changes on its rising edge.
REQ-004 Reset  input  1: asynchronous, active-low reset.
REQ-005 frame_clk  input  1: VGA VSync, asynchronous to game logic but sampled on Clk.
REQ-006 level_start  input  1: one-Clk pulse; begins a new level.
REQ-007 coin_hit  input  3: per-coin collision pulses from game logic; bit i means coin i was touched this cycle.
REQ-008 game_win  input  1: one-Clk pulse; player reached the goal.
REQ-009 game_lose  input  1: one-Clk pulse; player died.
REQ-010 CoinStatus  output  3: bit i = 1 means coin i is still uncollected (drawn); 0 means collected or revealed. Feeds the star and coin renderers directly.
REQ-011 collected_count  output  2: live number of collected coins, 0..3.
REQ-012 reveal_done  output  1: high while in DONE.
REQ-013 state_out  output  2: current FSM state encoding, for debug.

Function
REQ-014 Synchronise frame_clk through two flops; frame_tick = one-Clk pulse on the synchronised rising edge.
REQ-015 FSM states: IDLE, PLAY, REVEAL, DONE; encoding IDLE=0, PLAY=1, REVEAL=2, DONE=3.
REQ-016 IDLE -> PLAY on level_start; coin register loads 3'b111 that cycle.
REQ-017 In PLAY, coin register bit i clears on coin_hit[i]; multiple bits in the same cycle all clear; a hit on an already-cleared bit has no effect.
REQ-018 In PLAY, game_win -> REVEAL; game_lose -> IDLE; if both arrive in the same cycle, game_win wins.
REQ-019 In PLAY, coin_hit arriving in the same cycle as game_win is counted before the transition.
REQ-020 In PLAY, level_start reloads 3'b111 and stays in PLAY.
REQ-021 collected_count = number of zero bits in the coin register, registered with 1-cycle latency.
REQ-022 In PLAY and IDLE, CoinStatus equals the coin register.
REQ-023 On entry to REVEAL, shown count = 0 and CoinStatus = 3'b111.
REQ-024 In REVEAL, an 8-bit frame counter increments on frame_tick. When it reaches REVEAL_FRAMES, it resets to 0 and shown count increments, if shown count < collected_count.
REQ-025 In REVEAL, CoinStatus clears bits LSB-first to match shown count: 0 -> 111, 1 -> 110, 2 -> 100, 3 -> 000.
REQ-026 REVEAL -> DONE on the frame_tick where shown count == collected_count and the frame counter reaches REVEAL_FRAMES. With 0 coins collected, DONE is reached after exactly REVEAL_FRAMES ticks.
REQ-027 In REVEAL and DONE, coin_hit, game_win and game_lose are ignored.
REQ-028 In REVEAL or DONE, level_start goes to PLAY with 3'b111.
REQ-029 DONE holds CoinStatus steady until level_start.

Reset
REQ-030 Reset low asynchronously forces IDLE, coin register 3'b111, CoinStatus 3'b111, collected_count 0, reveal_done 0, frame counter 0, synchroniser flops 0.
REQ-031 Reset asserted mid-REVEAL abandons the reveal; no frame_tick is generated on the first synchronised edge after release unless frame_clk actually rises.

Configuration
REQ-032 Macro STAR_REVEAL_ANIM_EN defined: REVEAL state and frame counter are present, and behaviour is as in REQ-023 to REQ-026.
REQ-033 Macro STAR_REVEAL_ANIM_EN undefined: game_win goes PLAY -> DONE directly, CoinStatus holds the final coin register, and the frame counter logic is omitted.

Structure
REQ-034 Shared package game_pkg holds: coin_state_t enum (IDLE, PLAY, REVEAL, DONE), the constant NUM_COINS = 3, and the function count_zeros3.
REQ-035 Sub-module vsync_edge (2-flop synchroniser plus rising-edge detect) is instantiated once for frame_clk.

Verification
REQ-036 Reset low, then level_start -> CoinStatus = 111, state_out = 1, collected_count = 0.
REQ-037 In PLAY: coin_hit = 101, then 010 -> CoinStatus 010, then 000; collected_count 2, then 3.
REQ-038 REVEAL_FRAMES = 2, 2 coins collected, then game_win -> CoinStatus 111, then 110 after 2 frame_ticks, then 100 after 4; reveal_done rises at tick 4 and stays 100.
REQ-039 game_win and game_lose in the same cycle with coin_hit = 001 -> state REVEAL, collected_count 1.
REQ-040 Reset pulled low mid-REVEAL -> immediate IDLE and CoinStatus 111; frame_clk toggling afterward has no effect until level_start.
REQ-041 STAR_REVEAL_ANIM_EN undefined, 1 coin collected, game_win -> next cycle DONE, CoinStatus 110, reveal_done 1.
